fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, memory request/response handling and the IF/ID register.
// A RUN/KILL FSM drops the response to an in-flight request when a redirect lands mid-wait.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic               valid_out
);

    // Handshake: a request is outstanding whenever imem_req=1; imem_addr is held
    // until imem_ready=1, and a response is consumed only in a cycle with both high.
    typedef enum logic {RUN = 1'b0, KILL = 1'b1} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pending;
    logic [ADDR_W-1:0] pc_next_seq;
    logic              accept;

    assign imem_addr   = pc;
    assign accept      = imem_req && imem_ready;
    assign pc_next_seq = pc + ADDR_W'(4);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            pc        <= RESET_PC;
            pending   <= '0;
            imem_req  <= 1'b0;
            pc_out    <= '0;
            instr_out <= '0;
            valid_out <= 1'b0;
        end else begin
            imem_req <= 1'b1;
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        valid_out <= 1'b0;
                        instr_out <= '0;
                        if (imem_req && !imem_ready) begin
                            // Address must stay put until the stale response drains.
                            pending <= branch_addr;
                            state   <= KILL;
                        end else begin
                            pc <= branch_addr;
                        end
                    end else if (freeze) begin
                        // Hold everything; an accepted response is re-requested.
                        state <= RUN;
                    end else if (accept) begin
                        pc        <= pc_next_seq;
                        pc_out    <= pc_next_seq;
                        instr_out <= imem_rdata;
                        valid_out <= 1'b1;
                    end else begin
                        valid_out <= 1'b0;
                    end
                end
                KILL: begin
                    valid_out <= 1'b0;
                    instr_out <= '0;
                    if (branch_taken && imem_ready) begin
                        pc    <= branch_addr;
                        state <= RUN;
                    end else if (branch_taken) begin
                        pending <= branch_addr;
                    end else if (imem_ready) begin
                        pc    <= pending;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, freeze, branch-over-freeze,
// branch during a memory wait, bubbles, PC wrap and reset while a response is being killed.
module tb_fetch_stage;
    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;

    int total_cnt = 0;
    int pass_cnt  = 0;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .pc_out       (pc_out),
        .instr_out    (instr_out),
        .valid_out    (valid_out)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: two fixed words, everything else tagged with its address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: mem_word = 32'hE3A0_1005;
            32'h0000_0004: mem_word = 32'hE281_1001;
            default:       mem_word = {16'hC0DE, addr[15:0]};
        endcase
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                           input logic [31:0] instr, input logic valid);
        chk({tag, ".imem_addr"}, imem_addr, addr);
        chk({tag, ".pc_out"},    pc_out,    pc);
        chk({tag, ".instr_out"}, instr_out, instr);
        chk({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, valid});
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; imem_ready = 1'b1;

        // Reset for two cycles
        tick();
        chk("rst.imem_req", {31'd0, imem_req}, 32'd0);
        chk_out("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk("req_after_rst", {31'd0, imem_req}, 32'd1);
        chk_out("first_req", 32'h0, 32'h0, 32'h0, 1'b0);

        // Stream
        tick();
        chk_out("stream0", 32'h4, 32'h4, 32'hE3A0_1005, 1'b1);
        tick();
        chk_out("stream1", 32'h8, 32'h8, 32'hE281_1001, 1'b1);

        // Freeze three cycles at PC=8
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("freeze", 32'h8, 32'h8, 32'hE281_1001, 1'b1);
        end
        freeze = 1'b0;
        tick();
        chk_out("unfreeze", 32'hC, 32'hC, 32'hC0DE_0008, 1'b1);

        // Branch overrides freeze
        branch_taken = 1'b1; branch_addr = 32'h40; freeze = 1'b1;
        tick();
        chk_out("br_freeze", 32'h40, 32'hC, 32'h0, 1'b0);
        branch_taken = 1'b0; freeze = 1'b0;
        tick();
        chk_out("br_target", 32'h44, 32'h44, 32'hC0DE_0040, 1'b1);

        // Go to 0x10, then branch twice while the memory waits
        branch_taken = 1'b1; branch_addr = 32'h10;
        tick();
        chk_out("br_10", 32'h10, 32'h44, 32'h0, 1'b0);
        imem_ready = 1'b0; branch_addr = 32'h80;
        tick();
        chk_out("wait1", 32'h10, 32'h44, 32'h0, 1'b0);
        branch_addr = 32'h90;
        tick();
        chk_out("wait2", 32'h10, 32'h44, 32'h0, 1'b0);
        branch_taken = 1'b0; freeze = 1'b1;
        tick();
        chk_out("wait3", 32'h10, 32'h44, 32'h0, 1'b0);
        imem_ready = 1'b1;
        tick();
        chk_out("kill_drop", 32'h90, 32'h44, 32'h0, 1'b0);
        freeze = 1'b0;
        tick();
        chk_out("after_kill", 32'h94, 32'h94, 32'hC0DE_0090, 1'b1);

        // Bubble while memory not ready
        imem_ready = 1'b0;
        tick();
        chk_out("bubble", 32'h94, 32'h94, 32'hC0DE_0090, 1'b0);
        imem_ready = 1'b1;
        tick();
        chk_out("after_bubble", 32'h98, 32'h98, 32'hC0DE_0094, 1'b1);

        // PC wrap
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        tick();
        chk_out("br_top", 32'hFFFF_FFFC, 32'h98, 32'h0, 1'b0);
        branch_taken = 1'b0;
        tick();
        chk_out("wrap", 32'h0, 32'h0, 32'hC0DE_FFFC, 1'b1);
        tick();
        chk_out("post_wrap", 32'h4, 32'h4, 32'hE3A0_1005, 1'b1);

        // Enter KILL, then reset
        imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h200;
        tick();
        chk_out("kill_enter", 32'h4, 32'h4, 32'h0, 1'b0);
        rst = 1'b0; branch_taken = 1'b0;
        tick();
        chk("kill_rst.imem_req", {31'd0, imem_req}, 32'd0);
        chk_out("kill_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1; imem_ready = 1'b1;
        tick();
        chk_out("resume_req", 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        chk_out("resume", 32'h4, 32'h4, 32'hE3A0_1005, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
